// File: rtl/skeleton_bus_arbiter.sv
// Round-robin arbiter for the skeleton internal bus.
// One transfer in flight, windowed slave decode, timeout and decode errors.
module skeleton_bus_arbiter #(
  parameter int NUM_MASTERS = 1,
  parameter int NUM_SLAVES  = 1,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BASE_ADDR   = 4096,
  parameter int SLOT_SIZE   = 256,
  parameter int TIMEOUT     = 255,
  localparam int SW         = $clog2(SLOT_SIZE),
  localparam int SAW        = (SW > 0) ? SW : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_SLAVES-1:0]         s_sel,
  output logic                          s_wr,
  output logic [SAW-1:0]                s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [NUM_SLAVES-1:0]         s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rdata
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] req_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [MW-1:0]          last_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   err_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [NUM_SLAVES-1:0]  sel_q;
  logic                   wr_q;
  logic [SAW-1:0]         saddr_q;
  logic [DATA_W-1:0]      wdata_q;

  logic [MW-1:0]          win_d;
  logic                   win_vld;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [ADDR_W-1:0]      off_d;
  logic [ADDR_W-1:0]      idx_d;
  logic [DATA_W-1:0]      wd_d;
  logic [DATA_W-1:0]      srd_d;
  logic                   mapped_d;
  logic                   sack_d;

  // Descending scan so the nearest requester after last_q wins.
  always_comb begin : arb
    int c;
    c       = 0;
    win_d   = last_q;
    win_vld = 1'b0;
    gnt_d   = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      c = (int'(last_q) + k) % NUM_MASTERS;
      if (req_q[c]) begin
        win_d   = MW'(c);
        gnt_d   = NUM_MASTERS'(1) << c;
        win_vld = 1'b1;
      end
    end
    addr_d = '0;
    wd_d   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_d[i]) begin
        addr_d = m_addr[i*ADDR_W +: ADDR_W];
        wd_d   = m_wdata[i*DATA_W +: DATA_W];
      end
    end
    srd_d = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (sel_q[j]) srd_d = s_rdata[j*DATA_W +: DATA_W];
    end
  end

  // Below-base addresses must not wrap into a window.
  assign off_d    = addr_d - BASE;
  assign idx_d    = off_d >> SW;
  assign mapped_d = (addr_d >= BASE) &&
                    (idx_d < ADDR_W'(NUM_SLAVES));
  assign cnt_d    = cnt_q + 1'b1;
  assign sack_d   = |(s_ack & sel_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      last_q  <= MW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      saddr_q <= '0;
      wdata_q <= '0;
    end else begin
      req_q <= m_req;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q <= gnt_d;
            last_q  <= win_d;
            wr_q    <= |(m_wr & gnt_d);
            wdata_q <= wd_d;
            if (mapped_d) begin
              state_q <= ACCESS;
              sel_q   <= NUM_SLAVES'(1) << idx_d;
              saddr_q <= (SW > 0) ? off_d[SAW-1:0] : '0;
            end else begin
              state_q <= RESP;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_d;
          if (sack_d) begin
            state_q <= RESP;
            sel_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= wr_q ? '0 : srd_d;
          end else if (cnt_d == CW'(TIMEOUT)) begin
            state_q <= RESP;
            sel_q   <= '0;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        RESP: begin
          if (ack_q == '0) begin
            ack_q <= grant_q;
          end else begin
            state_q <= IDLE;
            ack_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_grant = grant_q;
  assign m_ack   = ack_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign s_sel   = sel_q;
  assign s_wr    = wr_q;
  assign s_addr  = saddr_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_skeleton_bus_arbiter.sv
// Bench for skeleton_bus_arbiter: 3 masters, 1 slave window.
// Directed scenarios plus randomized batches against a round-robin model.
module tb_skeleton_bus_arbiter;

  localparam int NM   = 3;
  localparam int NS   = 1;
  localparam int BASE = 4096;
  localparam int SLOT = 256;
  localparam int TMO  = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_wr;
  logic [NM-1:0][15:0] ma;
  logic [NM-1:0][15:0] mwd;
  logic [NM-1:0]    m_grant;
  logic [NM-1:0]    m_ack;
  logic             m_err;
  logic [15:0]      m_rdata;
  logic [NS-1:0]    s_sel;
  logic             s_wr;
  logic [7:0]       s_addr;
  logic [15:0]      s_wdata;
  logic [NS-1:0]    s_ack;
  logic [15:0]      s_rdata;

  int chk = 0;
  int errs = 0;
  int exp_last;

  typedef struct {
    logic          got;
    int            lat;
    logic [NM-1:0] ack;
    logic [NM-1:0] gnt;
    logic          err;
    logic [15:0]   rd;
    int            sel_cyc;
    logic [NS-1:0] sel;
    logic [7:0]    saddr;
    logic          swr;
    logic [15:0]   swd;
    logic          stable;
    logic [NM-1:0] ack_nxt;
    logic [NM-1:0] gnt_nxt;
  } obs_t;

  always #5 clk = ~clk;

  skeleton_bus_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS),
    .ADDR_W(16), .DATA_W(16),
    .BASE_ADDR(BASE), .SLOT_SIZE(SLOT),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_wr(m_wr),
    .m_addr(ma), .m_wdata(mwd),
    .m_grant(m_grant), .m_ack(m_ack),
    .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_wr(s_wr),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  function automatic int rr_pick(input int last,
                                 input logic [NM-1:0] req);
    int c;
    for (int k = 1; k <= NM; k++) begin
      c = (last + k) % NM;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic is_mapped(input int a);
    return (a >= BASE) && ((a - BASE) / SLOT < NS);
  endfunction

  task automatic set_m(input int i, input logic w,
                       input int a, input logic [15:0] d);
    m_wr[i] = w;
    ma[i]   = 16'(a);
    mwd[i]  = d;
  endtask

  // mode 0: owner drops on ack, 1: all keep, 2: all drop
  task automatic run_xfer(input int dly, input logic [15:0] rdv,
                          input int mode, output obs_t o);
    o = '{default: 0};
    o.stable = 1'b1;
    s_rdata = rdv;
    for (int t = 1; t <= 400 && !o.got; t++) begin
      @(negedge clk);
      if (s_sel != '0) begin
        if (o.sel_cyc == 0) begin
          o.sel = s_sel; o.saddr = s_addr;
          o.swr = s_wr;  o.swd = s_wdata;
        end else if ({s_sel, s_addr, s_wr, s_wdata} !==
                     {o.sel, o.saddr, o.swr, o.swd}) begin
          o.stable = 1'b0;
        end
        s_ack = (dly >= 0 && o.sel_cyc == dly) ? '1 : '0;
        o.sel_cyc++;
      end else begin
        s_ack = '0;
      end
      if (m_ack != '0) begin
        o.got = 1'b1; o.lat = t;
        o.ack = m_ack; o.gnt = m_grant;
        o.err = m_err; o.rd = m_rdata;
        if (mode == 0) m_req = m_req & ~m_ack;
        else if (mode == 2) m_req = '0;
      end
    end
    s_ack = '0;
    if (!o.got) m_req = '0;
    else begin
      @(negedge clk);
      o.ack_nxt = m_ack;
      o.gnt_nxt = m_grant;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk++;
    if ({m_grant, m_ack, m_err, m_rdata} !== '0) begin
      errs++;
      $display("FAIL reset_master got %h exp 0",
               {m_grant, m_ack, m_err, m_rdata});
    end
    chk++;
    if ({s_sel, s_wr, s_addr, s_wdata} !== '0) begin
      errs++;
      $display("FAIL reset_slave got %h exp 0",
               {s_sel, s_wr, s_addr, s_wdata});
    end
    reset = 1'b0;
    exp_last = NM - 1;
    repeat (2) @(negedge clk);
    chk++;
    if ({m_grant, s_sel} !== '0) begin
      errs++;
      $display("FAIL idle_no_req got %h exp 0", {m_grant, s_sel});
    end
  endtask

  task automatic test_write;
    obs_t o;
    int own;
    logic [NM-1:0] eoh;
    set_m(0, 1'b1, BASE + 5, 16'hBEEF);
    m_req = 3'b001;
    own = rr_pick(exp_last, m_req);
    exp_last = own;
    eoh = 3'b001 << own;
    run_xfer(0, 16'h5A5A, 0, o);
    chk++;
    if (!o.got || o.lat != 4) begin
      errs++;
      $display("FAIL write_lat got %0d exp 4", o.lat);
    end
    chk++;
    if ({o.ack, o.gnt} !== {eoh, eoh}) begin
      errs++;
      $display("FAIL write_owner got %b/%b exp %b",
               o.ack, o.gnt, eoh);
    end
    chk++;
    if ({o.sel, o.saddr, o.swr, o.swd} !==
        {1'b1, 8'd5, 1'b1, 16'hBEEF}) begin
      errs++;
      $display("FAIL write_slave got %b %0d %b %h exp 1 5 1 beef",
               o.sel, o.saddr, o.swr, o.swd);
    end
    chk++;
    if ({o.err, o.rd} !== {1'b0, 16'h0}) begin
      errs++;
      $display("FAIL write_resp got err %b rd %h exp 0 0",
               o.err, o.rd);
    end
    chk++;
    if ({o.ack_nxt, o.gnt_nxt} !== '0) begin
      errs++;
      $display("FAIL ack_pulse got %b/%b exp 0",
               o.ack_nxt, o.gnt_nxt);
    end
  endtask

  task automatic test_reads;
    obs_t o;
    int addrs [3] = '{BASE + 255, BASE + SLOT, BASE - 1};
    for (int n = 0; n < 3; n++) begin
      set_m(2, 1'b0, addrs[n], 16'h0);
      m_req = 3'b100;
      exp_last = rr_pick(exp_last, m_req);
      run_xfer(0, 16'h1234, 0, o);
      if (n == 0) begin
        chk++;
        if ({o.got, o.saddr, o.err, o.rd} !==
            {1'b1, 8'd255, 1'b0, 16'h1234} || o.lat != 4) begin
          errs++;
          $display("FAIL read_top got a %0d err %b rd %h lat %0d",
                   o.saddr, o.err, o.rd, o.lat);
        end
      end else begin
        chk++;
        if ({o.got, o.err, o.rd} !== {1'b1, 1'b1, 16'h0} ||
            o.lat != 3 || o.sel_cyc != 0) begin
          errs++;
          $display("FAIL unmapped_%0d got err %b rd %h lat %0d sel %0d",
                   addrs[n], o.err, o.rd, o.lat, o.sel_cyc);
        end
      end
      chk++;
      if (o.ack !== 3'b100) begin
        errs++;
        $display("FAIL read_owner_%0d got %b exp 100", n, o.ack);
      end
    end
  endtask

  task automatic test_fairness;
    obs_t o;
    int own;
    logic [NM-1:0] eoh;
    for (int i = 0; i < NM; i++)
      set_m(i, 1'b0, BASE + 16 * i, 16'h0);
    m_req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      own = rr_pick(exp_last, m_req);
      exp_last = own;
      eoh = 3'b001 << own;
      run_xfer(0, 16'(n + 100), (n == 5) ? 2 : 1, o);
      chk++;
      if ({o.got, o.ack, o.gnt, o.rd} !==
          {1'b1, eoh, eoh, 16'(n + 100)}) begin
        errs++;
        $display("FAIL rr_%0d got ack %b rd %0d exp %b %0d",
                 n, o.ack, o.rd, eoh, n + 100);
      end
    end
  endtask

  task automatic test_timeout;
    obs_t o;
    set_m(1, 1'b0, BASE + 104, 16'h0);
    m_req = 3'b010;
    exp_last = rr_pick(exp_last, m_req);
    run_xfer(-1, 16'hAAAA, 0, o);
    chk++;
    if ({o.got, o.err, o.rd, o.ack} !== {1'b1, 1'b1, 16'h0, 3'b010} ||
        o.lat != TMO + 3 || o.sel_cyc != TMO) begin
      errs++;
      $display("FAIL timeout got err %b rd %h lat %0d sel %0d",
               o.err, o.rd, o.lat, o.sel_cyc);
    end
    chk++;
    if (!o.stable || o.saddr !== 8'd104) begin
      errs++;
      $display("FAIL access_stable got %b a %0d exp 1 104",
               o.stable, o.saddr);
    end
    m_req = 3'b010;
    exp_last = rr_pick(exp_last, m_req);
    run_xfer(TMO - 1, 16'hC0DE, 0, o);
    chk++;
    if ({o.got, o.err, o.rd} !== {1'b1, 1'b0, 16'hC0DE} ||
        o.lat != TMO + 3 || o.sel_cyc != TMO) begin
      errs++;
      $display("FAIL ack_at_timeout got err %b rd %h lat %0d",
               o.err, o.rd, o.lat);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int own;
    set_m(0, 1'b0, BASE + 7, 16'h0);
    set_m(1, 1'b0, BASE + 9, 16'h0);
    m_req = 3'b001;
    for (int t = 0; t < 20 && s_sel == '0; t++) @(negedge clk);
    chk++;
    if (s_sel !== 1'b1) begin
      errs++;
      $display("FAIL reach_access got %b exp 1", s_sel);
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk++;
    if ({s_sel, m_grant, m_ack} !== '0) begin
      errs++;
      $display("FAIL async_reset got %b exp 0",
               {s_sel, m_grant, m_ack});
    end
    m_req = '0;
    exp_last = NM - 1;
    repeat (2) @(negedge clk);
    chk++;
    if ({m_ack, m_grant} !== '0) begin
      errs++;
      $display("FAIL ack_in_reset got %b exp 0", {m_ack, m_grant});
    end
    reset = 1'b0;
    @(negedge clk);
    m_req = 3'b011;
    for (int n = 0; n < 2; n++) begin
      own = rr_pick(exp_last, m_req);
      exp_last = own;
      run_xfer(0, 16'(n + 1), 0, o);
      chk++;
      if ({o.got, o.ack, o.rd} !==
          {1'b1, 3'(3'b001 << own), 16'(n + 1)}) begin
        errs++;
        $display("FAIL post_reset_%0d got %b exp owner %0d",
                 n, o.ack, own);
      end
    end
  endtask

  task automatic test_random;
    obs_t o;
    int own, a, dly, erd, g;
    logic [15:0] rdv;
    logic mp;
    logic [NM-1:0] eoh;
    int edges [4] = '{BASE - 1, BASE, BASE + SLOT - 1, BASE + SLOT};
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < NM; i++) begin
        case ($urandom_range(0, 3))
          0: a = BASE + int'($urandom_range(0, SLOT - 1));
          1: a = int'($urandom_range(0, BASE - 1));
          2: a = int'($urandom_range(BASE + NS * SLOT, 65535));
          default: a = edges[$urandom_range(0, 3)];
        endcase
        set_m(i, 1'($urandom_range(0, 1)), a, 16'($urandom));
      end
      m_req = 3'($urandom_range(1, 7));
      g = 0;
      while (m_req != '0 && g < NM) begin
        g++;
        own = rr_pick(exp_last, m_req);
        exp_last = own;
        eoh = 3'b001 << own;
        dly = int'($urandom_range(0, 3));
        rdv = 16'($urandom);
        run_xfer(dly, rdv, 0, o);
        a = int'(ma[own]);
        mp = is_mapped(a);
        erd = (mp && !m_wr[own]) ? int'(rdv) : 0;
        chk++;
        if ({o.got, o.ack, o.gnt} !== {1'b1, eoh, eoh}) begin
          errs++;
          $display("FAIL rand_owner b%0d got %b/%b exp %b",
                   b, o.ack, o.gnt, eoh);
        end
        chk++;
        if ({o.err, o.rd} !== {!mp, 16'(erd)}) begin
          errs++;
          $display("FAIL rand_resp a %0d got %b %h exp %b %h",
                   a, o.err, o.rd, !mp, 16'(erd));
        end
        chk++;
        if (o.sel_cyc != (mp ? dly + 1 : 0) ||
            (mp && {o.saddr, o.swr, o.swd} !==
             {8'((a - BASE) % SLOT), m_wr[own], mwd[own]})) begin
          errs++;
          $display("FAIL rand_slave a %0d got n%0d %0d %b %h",
                   a, o.sel_cyc, o.saddr, o.swr, o.swd);
        end
      end
      m_req = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    m_req   = '0;
    m_wr    = '0;
    ma      = '0;
    mwd     = '0;
    s_ack   = '0;
    s_rdata = '0;
    test_reset;
    test_write;
    test_reads;
    test_fairness;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule

// File: doc/skeleton_bus_arbiter.md
Name: skeleton_bus_arbiter

Overview:
Shares the skeleton internal bus between NUM_MASTERS requesters and routes each granted transfer to one of NUM_SLAVES address windows. The first window is the test RAM (base 4096, 256 words). Each later slave occupies the next SLOT_SIZE-word window. Arbitration is round-robin with one outstanding transfer at a time. Slaves that never answer are timed out, and unmapped addresses get an error response.

Parameters:
NUM_MASTERS, 1, number of requesting masters (1..8)
NUM_SLAVES, 1, number of slave windows (1..8)
ADDR_W, 16, address width
DATA_W, 16, data width
BASE_ADDR, 4096, start of slave 0 window (test RAM offset)
SLOT_SIZE, 256, words per slave window; power of two
TIMEOUT, 255, cycles in ACCESS before error termination

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
m_req  in  NUM_MASTERS  per-master transfer request, level, held until m_ack
m_wr  in  NUM_MASTERS  1 = write, 0 = read
m_addr  in  NUM_MASTERS*ADDR_W  flattened addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_MASTERS*DATA_W  flattened write data
m_grant  out  NUM_MASTERS  one-hot, current owner
m_ack  out  NUM_MASTERS  one-cycle completion pulse to owner
m_err  out  1  valid with m_ack: timeout or unmapped
m_rdata  out  DATA_W  read data, valid with m_ack
s_sel  out  NUM_SLAVES  one-hot slave strobe, held during ACCESS
s_wr  out  1  latched direction
s_addr  out  log2(SLOT_SIZE)  window-local address (addr - window base)
s_wdata  out  DATA_W  latched write data
s_ack  in  NUM_SLAVES  per-slave completion
s_rdata  in  NUM_SLAVES*DATA_W  flattened slave read data

Behaviour:
- Reset (async): state = IDLE. All outputs are 0. Round-robin pointer last = NUM_MASTERS-1, so master 0 has first priority. The timeout counter is 0.
- FSM states are IDLE, ACCESS and RESP. All outputs are registered.
- IDLE:
  - If m_req is nonzero, pick the first requesting master scanning last+1, last+2, … (mod NUM_MASTERS).
  - Latch its addr, wr and wdata, set m_grant one-hot, and set last = winner.
  - Decode: idx = (addr - BASE_ADDR) / SLOT_SIZE. Mapped means addr >= BASE_ADDR and idx < NUM_SLAVES. Use unsigned compare, and no wrap: an address below BASE_ADDR is unmapped.
  - Mapped: go to ACCESS. s_sel[idx] = 1 and s_addr = (addr - BASE_ADDR) mod SLOT_SIZE.
  - Unmapped: go to RESP with err = 1. No slave strobe.
- ACCESS:
  - s_sel, s_wr, s_addr and s_wdata are stable. The counter increments each cycle.
  - s_ack[idx] = 1: capture s_rdata[idx] (reads; write rdata = 0), err = 0, go to RESP.
  - Counter reaches TIMEOUT without ack: err = 1, rdata = 0, go to RESP.
  - An ack on the same cycle as the timeout wins (err = 0).
  - Acks from unselected slaves are ignored.
- RESP:
  - s_sel = 0. m_ack[owner] = 1 for exactly one cycle, with m_rdata and m_err.
  - Next cycle: m_grant = 0, m_ack = 0, counter = 0, go to IDLE.
- Latency: mapped transfer with slave ack in its first ACCESS cycle = request sampled at edge N, m_ack high after edge N+3. Unmapped = m_ack high after edge N+2.
- Masters must drop m_req in the cycle m_ack is seen. A request still high in IDLE after RESP is treated as a new transfer.
- A master dropping m_req mid-transfer does not abort it; the ack is still issued.
- Minimum one IDLE cycle between transfers. Fairness means no master waits more than NUM_MASTERS-1 transfers.
- Reset mid-transfer: immediate return to the reset state, with no ack issued.

Test Plan:
- 1 master write addr 4096+5, data 0xBEEF, slave acks on its first ACCESS cycle -> s_sel=1, s_addr=5, s_wr=1, s_wdata=0xBEEF; m_ack after 3 edges; m_err=0.
- Read addr 4351 returns 0x1234 -> s_addr=255, m_rdata=0x1234. Read addr 4352 with NUM_SLAVES=1 -> no s_sel; m_ack after 2 edges, m_err=1.
- Read addr 4095 (just below base) -> unmapped, m_err=1, m_rdata=0.
- NUM_MASTERS=3, all request continuously -> grants in order 0,1,2,0,1,2; no master is granted twice while another waits.
- Slave never acks, TIMEOUT=255 -> s_sel held 255 cycles, then m_ack with m_err=1 and m_rdata=0.
- Assert reset during ACCESS -> s_sel, m_grant and m_ack are 0 immediately. After release, the next request goes to master 0 first.
